mem_stage: RTL

- Memory-access stage of the five-stage pipeline, directly downstream of the execute stage.
- Takes the execute stage's ALU result, memory address, store data and instruction class, and runs a req/ack transaction on the data bus for loads and stores.
- Aligns and extends load data, and registers the write-back bundle for the WB stage.
- Holds the pipeline through `stallreq` while a bus transaction is outstanding.

---
 rtl/mem_stage.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: issues req/ack data-bus transactions for loads and stores, aligns and
// extends load data, and registers the write-back bundle while stalling upstream when busy.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [6:0]  ex_aluop,
  input  logic [2:0]  ex_sel,
  input  logic        ex_reg_we,
  input  logic [31:0] ex_reg_waddr,
  input  logic [31:0] ex_reg_data,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_data,
  input  logic        flush,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        stallreq,
  output logic        wb_valid,
  output logic        wb_reg_we,
  output logic [31:0] wb_reg_waddr,
  output logic [31:0] wb_reg_data,
  output logic        mem_misalign,
  output logic        bus_err
);

  localparam logic [6:0] INST_TYPE_I_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S   = 7'b0100011;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_load_q, is_load_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        reg_we_q, reg_we_d;
  logic [31:0] waddr_q, waddr_d;
  logic        kill_q, kill_d;
  logic        err_q, err_d;
  logic [31:0] ld_q, ld_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_waddr_q, wb_waddr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        is_load, is_mem, misalign, kill;
  logic [1:0]  size;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, lane, ld_fmt;

  // Instruction decode; unknown funct3 falls back to a word access.
  always_comb begin
    is_load = ex_aluop == INST_TYPE_I_L;
    is_mem  = ex_valid && (is_load || ex_aluop == INST_TYPE_S);
    case (ex_sel)
      3'd0:    size = SzByte;
      3'd1:    size = SzHalf;
      3'd4:    size = is_load ? SzByte : SzWord;
      3'd5:    size = is_load ? SzHalf : SzWord;
      default: size = SzWord;
    endcase
    misalign = (size == SzHalf && ex_mem_addr[0]) ||
               (size == SzWord && ex_mem_addr[1:0] != 2'b00);
    case (size)
      SzByte: begin
        st_be    = 4'b0001 << ex_mem_addr[1:0];
        st_wdata = {4{ex_mem_data[7:0]}};
      end
      SzHalf: begin
        st_be    = 4'b0011 << ex_mem_addr[1:0];
        st_wdata = {2{ex_mem_data[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = ex_mem_data;
      end
    endcase
  end

  always_comb begin
    lane = dbus_rdata >> {off_q, 3'b000};
    case (size_q)
      SzByte:  ld_fmt = uns_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SzHalf:  ld_fmt = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_fmt = lane;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    is_load_d  = is_load_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    reg_we_d   = reg_we_q;
    waddr_d    = waddr_q;
    kill_d     = kill_q;
    err_d      = err_q;
    ld_d       = ld_q;
    wb_valid_d = wb_valid_q;
    wb_we_d    = wb_we_q;
    wb_waddr_d = wb_waddr_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stallreq   = 1'b0;
    kill       = kill_q | flush;

    case (state_q)
      StIdle: begin
        wb_valid_d = ex_valid & ~flush;
        wb_we_d    = ex_reg_we & ex_valid & ~flush;
        wb_waddr_d = ex_reg_waddr;
        wb_data_d  = ex_reg_data;
        if (is_mem && !flush) begin
          wb_we_d = 1'b0;
          if (misalign) begin
            misalign_d = 1'b1;
          end else begin
            stallreq   = 1'b1;
            wb_valid_d = 1'b0;
            req_d      = 1'b1;
            we_d       = ~is_load;
            addr_d     = {ex_mem_addr[31:2], 2'b00};
            be_d       = is_load ? 4'hF : st_be;
            wdata_d    = is_load ? 32'h0 : st_wdata;
            cnt_d      = 8'd0;
            is_load_d  = is_load;
            size_d     = size;
            uns_d      = ex_sel[2];
            off_d      = ex_mem_addr[1:0];
            reg_we_d   = ex_reg_we;
            waddr_d    = ex_reg_waddr;
            kill_d     = 1'b0;
            err_d      = 1'b0;
            state_d    = StBusy;
          end
        end
      end
      StBusy: begin
        stallreq = 1'b1;
        kill_d   = kill;
        if (dbus_ack) begin
          req_d   = 1'b0;
          ld_d    = ld_fmt;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          ld_d    = 32'h0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        // Upstream advances on this edge; the held instruction is retired, never re-issued.
        wb_valid_d = ~kill;
        wb_we_d    = reg_we_q & is_load_q & ~err_q & ~kill;
        wb_waddr_d = waddr_q;
        wb_data_d  = ld_q;
        bus_err_d  = err_q & ~kill;
        kill_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      is_load_q  <= 1'b0;
      size_q     <= SzByte;
      uns_q      <= 1'b0;
      off_q      <= 2'b00;
      reg_we_q   <= 1'b0;
      waddr_q    <= 32'h0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
      ld_q       <= 32'h0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= 32'h0;
      wb_data_q  <= 32'h0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      is_load_q  <= is_load_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      reg_we_q   <= reg_we_d;
      waddr_q    <= waddr_d;
      kill_q     <= kill_d;
      err_q      <= err_d;
      ld_q       <= ld_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dbus_req     = req_q;
  assign dbus_we      = we_q;
  assign dbus_addr    = addr_q;
  assign dbus_be      = be_q;
  assign dbus_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_we    = wb_we_q;
  assign wb_reg_waddr = wb_waddr_q;
  assign wb_reg_data  = wb_data_q;
  assign mem_misalign = misalign_q;
  assign bus_err      = bus_err_q;

endmodule
